// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP definitions for the IPv4 TX-path ARP client.
//   ETH_TYPE_IPV4 : EtherType inserted in every emitted header
//   MAC_BCAST     : all-ones MAC used for IP broadcast destinations
//   MCAST_OUI     : IANA prefix of IPv4 multicast MACs
//   arp_state_t   : lookup FSM states
package eth_pkg;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [47:0] MAC_BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [23:0] MCAST_OUI     = 24'h01005E;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } arp_state_t;
endpackage

// File: rtl/ip_next_hop.sv
// Combinational destination classifier.
//   i_dest_ip/i_local_ip/i_subnet_mask/i_gateway_ip : addressing inputs
//   o_bypass     : destination needs no ARP lookup (broadcast/multicast)
//   o_bypass_mac : MAC to use when o_bypass is set
//   o_next_hop   : IP to resolve via ARP when o_bypass is clear
module ip_next_hop
  import eth_pkg::*;
(
  input  logic [31:0] i_dest_ip,
  input  logic [31:0] i_local_ip,
  input  logic [31:0] i_subnet_mask,
  input  logic [31:0] i_gateway_ip,
  output logic        o_bypass,
  output logic [47:0] o_bypass_mac,
  output logic [31:0] o_next_hop
);
  logic w_bcast, w_mcast, w_local;

  assign w_bcast = (i_dest_ip == 32'hFFFF_FFFF) ||
                   (i_dest_ip == (i_local_ip | ~i_subnet_mask));
  assign w_mcast = (i_dest_ip[31:28] == 4'hE);
  assign w_local = ((i_dest_ip & i_subnet_mask) == (i_local_ip & i_subnet_mask));

  assign o_bypass = w_bcast | w_mcast;

  // Broadcast takes precedence over the multicast mapping.
  always_comb begin
    o_bypass_mac = MAC_BCAST;
    if (!w_bcast) o_bypass_mac = {MCAST_OUI, 1'b0, i_dest_ip[22:0]};
  end

  // Off-subnet traffic is resolved through the default gateway.
  assign o_next_hop = w_local ? i_dest_ip : i_gateway_ip;
endmodule

// File: rtl/ip_arp_lookup.sv
// ARP client on the IPv4 TX path: takes an IP header (dest IP) plus a byte
// payload, resolves the next-hop MAC and emits an Ethernet header followed by
// the unmodified payload.
//   s_ip_hdr_*          : incoming frame header (dest IP)
//   s_ip_payload_axis_* : incoming payload stream
//   m_eth_hdr_*         : outgoing Ethernet header (dest/src MAC, type)
//   m_eth_payload_axis_*: outgoing payload stream (pass-through)
//   arp_request_*       : lookup request to the ARP block
//   arp_response_*      : lookup result from the ARP block
//   local_mac/local_ip/gateway_ip/subnet_mask : live configuration
//   drop_pulse          : one cycle per dropped frame
//   busy                : a frame is in flight
module ip_arp_lookup
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int LOOKUP_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_ip_hdr_valid,
  output logic                  s_ip_hdr_ready,
  input  logic [31:0]           s_ip_dest_ip,
  input  logic [DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
  input  logic                  s_ip_payload_axis_tvalid,
  output logic                  s_ip_payload_axis_tready,
  input  logic                  s_ip_payload_axis_tlast,
  input  logic                  s_ip_payload_axis_tuser,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  arp_request_valid,
  input  logic                  arp_request_ready,
  output logic [31:0]           arp_request_ip,
  input  logic                  arp_response_valid,
  output logic                  arp_response_ready,
  input  logic                  arp_response_error,
  input  logic [47:0]           arp_response_mac,
  input  logic [47:0]           local_mac,
  input  logic [31:0]           local_ip,
  input  logic [31:0]           gateway_ip,
  input  logic [31:0]           subnet_mask,
  output logic                  drop_pulse,
  output logic                  busy
);
  localparam int            CW       = $clog2(LOOKUP_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOOKUP_TIMEOUT - 1);

  arp_state_t  r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_next_hop;
  logic [47:0] r_dest_mac;
  logic        r_drop_pulse;
  // Holds header ready low for the cycle in which reset is still asserted,
  // so nothing is accepted until the block is really out of reset.
  logic        r_live;

  logic        w_bypass;
  logic [47:0] w_bypass_mac;
  logic [31:0] w_next_hop;

  ip_next_hop u_next_hop (
    .i_dest_ip     (s_ip_dest_ip),
    .i_local_ip    (local_ip),
    .i_subnet_mask (subnet_mask),
    .i_gateway_ip  (gateway_ip),
    .o_bypass      (w_bypass),
    .o_bypass_mac  (w_bypass_mac),
    .o_next_hop    (w_next_hop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_next_hop   <= '0;
      r_dest_mac   <= '0;
      r_drop_pulse <= 1'b0;
      r_live       <= 1'b0;
    end else begin
      r_live       <= 1'b1;
      r_drop_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (s_ip_hdr_valid && r_live) begin
            if (w_bypass) begin
              r_dest_mac <= w_bypass_mac;
              r_state    <= ST_HDR;
            end else begin
              r_next_hop <= w_next_hop;
              r_state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (arp_request_ready) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A good response beats a timeout landing in the same cycle.
          if (arp_response_valid && !arp_response_error) begin
            r_dest_mac <= arp_response_mac;
            r_state    <= ST_HDR;
          end else if (arp_response_valid || (r_cnt == CNT_LAST)) begin
            r_drop_pulse <= 1'b1;
            r_state      <= ST_DROP;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HDR: begin
          if (m_eth_hdr_ready) r_state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (s_ip_payload_axis_tvalid && m_eth_payload_axis_tready && s_ip_payload_axis_tlast)
            r_state <= ST_IDLE;
        end
        ST_DROP: begin
          if (s_ip_payload_axis_tvalid && s_ip_payload_axis_tlast) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ip_hdr_ready     = (r_state == ST_IDLE) && r_live;
  assign arp_request_valid  = (r_state == ST_REQ);
  assign arp_request_ip     = r_next_hop;
  assign arp_response_ready = (r_state == ST_WAIT);

  assign m_eth_hdr_valid = (r_state == ST_HDR);
  assign m_eth_dest_mac  = r_dest_mac;
  assign m_eth_src_mac   = local_mac;
  assign m_eth_type      = ETH_TYPE_IPV4;

  // Payload is only pulled once the header has gone out (or the frame is
  // being discarded); there is no buffering anywhere.
  assign s_ip_payload_axis_tready = ((r_state == ST_PAYLOAD) && m_eth_payload_axis_tready) ||
                                    (r_state == ST_DROP);
  assign m_eth_payload_axis_tvalid = (r_state == ST_PAYLOAD) && s_ip_payload_axis_tvalid;
  assign m_eth_payload_axis_tdata  = s_ip_payload_axis_tdata;
  assign m_eth_payload_axis_tlast  = s_ip_payload_axis_tlast;
  assign m_eth_payload_axis_tuser  = s_ip_payload_axis_tuser;

  assign drop_pulse = r_drop_pulse;
  assign busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_ip_arp_lookup.sv
module tb_ip_arp_lookup;
  localparam int DW  = 8;
  localparam int TMO = 16;
  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_ip_hdr_valid = 1'b0, s_ip_hdr_ready;
  logic [31:0] s_ip_dest_ip = '0;
  logic [DW-1:0] s_tdata = '0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic m_eth_hdr_valid, m_eth_hdr_ready = 1'b1;
  logic [47:0] m_eth_dest_mac, m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [DW-1:0] m_tdata;
  logic m_tvalid, m_tready = 1'b1, m_tlast, m_tuser;
  logic arp_request_valid, arp_request_ready = 1'b0;
  logic [31:0] arp_request_ip;
  logic arp_response_valid = 1'b0, arp_response_ready, arp_response_error = 1'b0;
  logic [47:0] arp_response_mac = '0;
  logic drop_pulse, busy;

  ip_arp_lookup #(.DATA_WIDTH(DW), .LOOKUP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready), .s_ip_dest_ip(s_ip_dest_ip),
    .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tvalid(s_tvalid),
    .s_ip_payload_axis_tready(s_tready), .s_ip_payload_axis_tlast(s_tlast),
    .s_ip_payload_axis_tuser(s_tuser),
    .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
    .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
    .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tvalid(m_tvalid),
    .m_eth_payload_axis_tready(m_tready), .m_eth_payload_axis_tlast(m_tlast),
    .m_eth_payload_axis_tuser(m_tuser),
    .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip),
    .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
    .local_mac(LMAC), .local_ip(32'hC0A8_0164), .gateway_ip(32'hC0A8_0101),
    .subnet_mask(32'hFFFF_FF00),
    .drop_pulse(drop_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard queues
  logic [31:0] exp_arp_q[$];
  logic [47:0] exp_hdr_q[$];
  logic [8:0]  exp_pay_q[$];   // {tlast, tdata}
  int drops_seen = 0, exp_drops = 0;
  logic prev_drop = 1'b0;
  bit bp_en = 1'b0;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (arp_request_valid) begin
        if (exp_arp_q.size() == 0) chk("unexpected_arp_request", 1, 0);
        else if (arp_request_ready) chk("arp_request_ip", arp_request_ip, exp_arp_q.pop_front());
      end
      if (m_eth_hdr_valid && m_eth_hdr_ready) begin
        if (exp_hdr_q.size() == 0) chk("unexpected_eth_hdr", 1, 0);
        else begin
          chk("eth_dest_mac", m_eth_dest_mac, exp_hdr_q.pop_front());
          chk("eth_src_mac", m_eth_src_mac, LMAC);
          chk("eth_type", m_eth_type, 16'h0800);
        end
      end
      if (m_tvalid && m_tready) begin
        if (exp_pay_q.size() == 0) chk("unexpected_payload", 1, 0);
        else chk("payload_last_data", {m_tlast, m_tdata}, exp_pay_q.pop_front());
      end
      if (drop_pulse) drops_seen++;
      if (prev_drop) chk("drop_pulse_width", drop_pulse, 0);
      prev_drop = drop_pulse;
    end else begin
      prev_drop = 1'b0;
    end
  end

  // Downstream backpressure
  initial forever begin
    @(posedge clk); #1;
    if (bp_en) begin
      m_eth_hdr_ready = 1'($urandom_range(0, 1));
      m_tready        = 1'($urandom_range(0, 1));
    end else begin
      m_eth_hdr_ready = 1'b1;
      m_tready        = 1'b1;
    end
  end

  task automatic send_hdr(input logic [31:0] dest);
    @(posedge clk); #1;
    s_ip_hdr_valid = 1'b1;
    s_ip_dest_ip   = dest;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ip_hdr_ready) begin
        @(posedge clk); #1;
        s_ip_hdr_valid = 1'b0;
        return;
      end
    end
    chk("hdr_accept_timeout", 0, 1);
    s_ip_hdr_valid = 1'b0;
  endtask

  // Serves one ARP request; returns right after the request handshake edge
  // (+1) when respond is clear, so the caller can time the lookup window.
  task automatic arp_serve(input bit respond, input bit err, input logic [47:0] mac, input int delay);
    bit found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arp_request_valid) begin found = 1'b1; break; end
    end
    if (!found) begin chk("arp_request_seen", 0, 1); return; end
    @(posedge clk); #1; arp_request_ready = 1'b1;
    @(posedge clk); #1; arp_request_ready = 1'b0;
    if (!respond) return;
    repeat (delay) @(posedge clk);
    #1;
    arp_response_valid = 1'b1;
    arp_response_error = err;
    arp_response_mac   = mac;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arp_response_ready) begin found = 1'b1; break; end
    end
    if (!found) chk("arp_response_taken", 0, 1);
    @(posedge clk); #1;
    arp_response_valid = 1'b0;
    arp_response_error = 1'b0;
  endtask

  task automatic send_payload(input int n, input logic [7:0] base, input bit expect_out, input bit with_last);
    bit got;
    @(posedge clk); #1;
    for (int b = 0; b < n; b++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 8'(b);
      s_tlast  = with_last && (b == n - 1);
      if (expect_out) exp_pay_q.push_back({s_tlast, s_tdata});
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (s_tready) begin got = 1'b1; break; end
      end
      @(posedge clk); #1;
      if (!got) begin chk("payload_accept_timeout", 0, 1); break; end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic arp_frame(input logic [31:0] dest, input logic [31:0] hop, input logic [47:0] mac,
                           input int n, input logic [7:0] base);
    exp_arp_q.push_back(hop);
    exp_hdr_q.push_back(mac);
    send_hdr(dest);
    arp_serve(1'b1, 1'b0, mac, 2);
    send_payload(n, base, 1'b1, 1'b1);
  endtask

  task automatic bypass_frame(input logic [31:0] dest, input logic [47:0] mac, input int n,
                              input logic [7:0] base);
    exp_hdr_q.push_back(mac);
    send_hdr(dest);
    send_payload(n, base, 1'b1, 1'b1);
  endtask

  initial begin
    int k;
    // Reset state
    #12;
    chk("rst_hdr_ready", s_ip_hdr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_arp_req_valid", arp_request_valid, 0);
    chk("rst_eth_hdr_valid", m_eth_hdr_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_hdr_ready", s_ip_hdr_ready, 1);

    // Local-subnet lookup and gateway lookup
    arp_frame(32'hC0A8_0180, 32'hC0A8_0180, 48'h5A51_5253_5455, 4, 8'h01);
    arp_frame(32'h0808_0808, 32'hC0A8_0101, 48'h0A0B_0C0D_0E0F, 3, 8'h10);

    // Bypass: limited broadcast, subnet broadcast, multicast
    bypass_frame(32'hFFFF_FFFF, 48'hFFFF_FFFF_FFFF, 2, 8'h20);
    bypass_frame(32'hC0A8_01FF, 48'hFFFF_FFFF_FFFF, 2, 8'h24);
    bypass_frame(32'hEFC0_A801, 48'h0100_5E40_A801, 3, 8'h28);

    // Error reply: whole payload discarded
    exp_arp_q.push_back(32'hC0A8_0102);
    exp_drops++;
    send_hdr(32'hC0A8_0102);
    arp_serve(1'b1, 1'b1, 48'h0, 2);
    send_payload(10, 8'h40, 1'b0, 1'b1);
    @(negedge clk);
    chk("idle_after_drop", busy, 0);
    arp_frame(32'hC0A8_0105, 32'hC0A8_0105, 48'h1122_3344_5566, 4, 8'h50);

    // Timeout: no reply, drop 16 cycles after the request handshake
    exp_arp_q.push_back(32'hC0A8_0107);
    exp_drops++;
    send_hdr(32'hC0A8_0107);
    arp_serve(1'b0, 1'b0, 48'h0, 0);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      k++;
      if (drop_pulse) break;
    end
    chk("timeout_cycles", k, TMO);
    send_payload(3, 8'h60, 1'b0, 1'b1);

    // Response in the timeout cycle wins
    exp_arp_q.push_back(32'hC0A8_0108);
    exp_hdr_q.push_back(48'hAABB_CCDD_EEFF);
    send_hdr(32'hC0A8_0108);
    arp_serve(1'b1, 1'b0, 48'hAABB_CCDD_EEFF, TMO - 1);
    send_payload(2, 8'h70, 1'b1, 1'b1);

    // Random backpressure
    bp_en = 1'b1;
    arp_frame(32'h0A00_0001, 32'hC0A8_0101, 48'h0000_0000_BEEF, 8, 8'h80);
    bypass_frame(32'hEF00_0001, 48'h0100_5E00_0001, 5, 8'h90);
    bp_en = 1'b0;
    repeat (2) @(posedge clk);

    // Reset in the middle of a payload
    exp_arp_q.push_back(32'hC0A8_0109);
    exp_hdr_q.push_back(48'h0102_0304_0506);
    send_hdr(32'hC0A8_0109);
    arp_serve(1'b1, 1'b0, 48'h0102_0304_0506, 1);
    send_payload(2, 8'hA0, 1'b1, 1'b0);
    @(negedge clk);
    chk("busy_mid_payload", busy, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_hdr_ready", s_ip_hdr_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valids", {m_eth_hdr_valid, m_tvalid, s_tready, arp_request_valid,
                          arp_response_ready, drop_pulse}, 0);
    chk("midrst_dest_mac", m_eth_dest_mac, 0);
    chk("midrst_arp_ip", arp_request_ip, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_hdr_ready", s_ip_hdr_ready, 1);
    chk("midrst_release_busy", busy, 0);

    // Normal operation after reset
    arp_frame(32'hC0A8_0110, 32'hC0A8_0110, 48'hCAFE_0000_0110, 3, 8'hB0);

    repeat (5) @(posedge clk);
    chk("arp_queue_drained", exp_arp_q.size(), 0);
    chk("hdr_queue_drained", exp_hdr_q.size(), 0);
    chk("pay_queue_drained", exp_pay_q.size(), 0);
    chk("drop_count", drops_seen, exp_drops);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
